rv_wb_regfile_scoreboard: RTL

//  Writeback-side partner to the ID-stage operand forwarding logic: holds the architectural GPRs, accepts
//  WB-stage writes, supplies ID-stage operand values with same-cycle write-through, and tracks outstanding

---
 rtl/rv_wb_regfile_scoreboard_if.sv | 39 +++
 rtl/rv_wb_regfile_scoreboard.sv | 102 ++++++++++
 2 files changed

// File: rtl/rv_wb_regfile_scoreboard_if.sv
// Bundles the writeback, load-issue and ID-operand signals of the register file / load scoreboard.
interface rv_wb_regfile_scoreboard_if #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             wb_valid_i;
  logic [IDX_W-1:0] wb_rd_index_i;
  logic [XLEN-1:0]  wb_value_i;
  logic             wb_is_load_i;
  logic             issue_load_i;
  logic [IDX_W-1:0] issue_rd_index_i;
  logic             issue_ready_o;
  logic             id_valid_i;
  logic [IDX_W-1:0] id_ra_index_i;
  logic [IDX_W-1:0] id_rb_index_i;
  logic [XLEN-1:0]  id_ra_value_o;
  logic [XLEN-1:0]  id_rb_value_o;
  logic             stall_o;
  logic [CNT_W-1:0] outstanding_o;
  logic             sb_error_o;

  modport master (
    output wb_valid_i, wb_rd_index_i, wb_value_i, wb_is_load_i,
    output issue_load_i, issue_rd_index_i,
    output id_valid_i, id_ra_index_i, id_rb_index_i,
    input  issue_ready_o, id_ra_value_o, id_rb_value_o, stall_o, outstanding_o, sb_error_o
  );

  modport slave (
    input  wb_valid_i, wb_rd_index_i, wb_value_i, wb_is_load_i,
    input  issue_load_i, issue_rd_index_i,
    input  id_valid_i, id_ra_index_i, id_rb_index_i,
    output issue_ready_o, id_ra_value_o, id_rb_value_o, stall_o, outstanding_o, sb_error_o
  );
endinterface

// File: rtl/rv_wb_regfile_scoreboard.sv
// Architectural GPR file with WB write-through to the ID read ports, plus a per-register
// outstanding-load scoreboard that raises the ID stall and flags protocol violations.
module rv_wb_regfile_scoreboard #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                        clk_i,
  input logic                        reset_i,
  rv_wb_regfile_scoreboard_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                sb_error_q, sb_error_d;

  logic issue_ready;
  logic retire;
  logic retire_ok;
  logic issue_acc;
  logic haz_a, haz_b;

  // Issue gating uses the registered count only, so a same-cycle retire never frees a slot early.
  always_comb begin
    issue_ready = (count_q < CNT_W'(MAX_OUTSTANDING));
    retire      = bus.wb_valid_i && bus.wb_is_load_i;
    retire_ok   = retire && (count_q != '0) &&
                  ((bus.wb_rd_index_i == '0) || pending_q[bus.wb_rd_index_i]);
    issue_acc   = bus.issue_load_i && issue_ready;
  end

  always_comb begin
    regs_d     = regs_q;
    pending_d  = pending_q;
    count_d    = count_q;
    sb_error_d = sb_error_q;

    if (bus.wb_valid_i && (bus.wb_rd_index_i != '0)) begin
      regs_d[bus.wb_rd_index_i] = bus.wb_value_i;
    end

    // Clear before set so a same-register issue in the retire cycle keeps the bit.
    if (retire_ok) begin
      pending_d[bus.wb_rd_index_i] = 1'b0;
    end
    if (issue_acc && (bus.issue_rd_index_i != '0)) begin
      pending_d[bus.issue_rd_index_i] = 1'b1;
    end
    pending_d[0] = 1'b0;

    count_d = count_q + CNT_W'(issue_acc) - CNT_W'(retire_ok);

    if ((retire && !retire_ok) || (bus.issue_load_i && !issue_ready)) begin
      sb_error_d = 1'b1;
    end

    if (reset_i) begin
      regs_d     = '{default: '0};
      pending_d  = '0;
      count_d    = '0;
      sb_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    regs_q     <= regs_d;
    pending_q  <= pending_d;
    count_q    <= count_d;
    sb_error_q <= sb_error_d;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [IDX_W-1:0] idx);
    if (idx == '0) begin
      return '0;
    end
    if (bus.wb_valid_i && (bus.wb_rd_index_i == idx)) begin
      return bus.wb_value_i;
    end
    return regs_q[idx];
  endfunction

  // A retiring load's data is forwarded this cycle, so its register stops causing a stall now.
  function automatic logic hazard(input logic [IDX_W-1:0] idx);
    return (idx != '0) && pending_q[idx] &&
           !(retire && (bus.wb_rd_index_i == idx));
  endfunction

  always_comb begin
    haz_a             = hazard(bus.id_ra_index_i);
    haz_b             = hazard(bus.id_rb_index_i);
    bus.id_ra_value_o = read_port(bus.id_ra_index_i);
    bus.id_rb_value_o = read_port(bus.id_rb_index_i);
    bus.stall_o       = bus.id_valid_i && (haz_a || haz_b);
    bus.issue_ready_o = issue_ready;
    bus.outstanding_o = count_q;
    bus.sb_error_o    = sb_error_q;
  end
endmodule
